// File: rtl/axis_write_ctrl_if.sv
// Bundle of the request, write-data config, AXI AW/B and status signals
// shared by the write command sequencer and whatever sits around it.
interface axis_write_ctrl_if #(
   parameter int ADDR_WIDTH    = 32,
   parameter int CFG_DWIDTH    = 32,
   parameter int AXI_LEN_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0]    cfg_address;
   logic [CFG_DWIDTH-1:0]    cfg_length;
   logic                     cfg_val;
   logic                     cfg_rdy;
   logic [CFG_DWIDTH-1:0]    data_length;
   logic                     data_val;
   logic                     data_rdy;
   logic [ADDR_WIDTH-1:0]    axi_awaddr;
   logic [AXI_LEN_WIDTH-1:0] axi_awlen;
   logic                     axi_awvalid;
   logic                     axi_awready;
   logic [1:0]               axi_bresp;
   logic                     axi_bvalid;
   logic                     axi_bready;
   logic                     done;
   logic                     error;

   // Every channel: a transfer happens on the rising edge where valid and ready are
   // both high; valid never waits on ready, and payload holds while valid waits.
   modport master (
      input  cfg_address, cfg_length, cfg_val, data_rdy, axi_awready, axi_bresp, axi_bvalid,
      output cfg_rdy, data_length, data_val, axi_awaddr, axi_awlen, axi_awvalid, axi_bready,
             done, error
   );

   modport slave (
      output cfg_address, cfg_length, cfg_val, data_rdy, axi_awready, axi_bresp, axi_bvalid,
      input  cfg_rdy, data_length, data_val, axi_awaddr, axi_awlen, axi_awvalid, axi_bready,
             done, error
   );
endinterface

// File: rtl/axis_write_ctrl.sv
// Write command sequencer: accepts a transfer, forwards its length to the data unit,
// then issues 4 KB-safe AW bursts and counts B responses until the transfer is done.
module axis_write_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int CFG_DWIDTH      = 32,
   parameter int AXI_LEN_WIDTH   = 4,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int CONVERT_SHIFT   = 1,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                clk,
   input  logic                rst,
   axis_write_ctrl_if.master   bus,
   output logic [1:0]          state_o
);
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CFG_DWIDTH-1:0] MAX_BL  = CFG_DWIDTH'(2 ** AXI_LEN_WIDTH);
   localparam logic [OW-1:0]         MAX_OUT = OW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, DCFG, ADDR, DRAIN} state_t;

   state_t                   state_q;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [CFG_DWIDTH-1:0]    rem_q, rem_d;
   logic [AXI_LEN_WIDTH:0]   bl_q, bl_d;
   logic [OW-1:0]            outst_q, outst_d;
   logic [CFG_DWIDTH-1:0]    dlen_q;
   logic [AXI_LEN_WIDTH-1:0] awlen_q;
   logic                     cfg_rdy_q, data_val_q, awvalid_q, bready_q, done_q, error_q;
   logic                     cfg_hs, d_hs, aw_hs, b_hs;
   logic [CFG_DWIDTH:0]      beats;

   // Burst length limited by words left, the AXI maximum and the next 4 KB page edge.
   function automatic logic [AXI_LEN_WIDTH:0] calc_bl(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [CFG_DWIDTH-1:0] r);
      logic [12:0]           to4k;
      logic [CFG_DWIDTH-1:0] lim;
      to4k = (13'd4096 - {1'b0, a[11:0]}) >> OFF;
      lim  = MAX_BL;
      if (CFG_DWIDTH'(to4k) < lim) lim = CFG_DWIDTH'(to4k);
      if (r < lim) lim = r;
      return lim[AXI_LEN_WIDTH:0];
   endfunction

   always_comb begin
      cfg_hs  = (state_q == IDLE) & cfg_rdy_q & bus.cfg_val;
      d_hs    = data_val_q & bus.data_rdy;
      aw_hs   = awvalid_q & bus.axi_awready;
      b_hs    = bready_q & bus.axi_bvalid;
      outst_d = outst_q;
      if (aw_hs && !b_hs)      outst_d = outst_q + 1'b1;
      else if (!aw_hs && b_hs) outst_d = outst_q - 1'b1;
      addr_d  = addr_q + (ADDR_WIDTH'(bl_q) << OFF);
      rem_d   = rem_q - CFG_DWIDTH'(bl_q);
      bl_d    = calc_bl(addr_d, rem_d);
      beats   = ({1'b0, bus.cfg_length} + (CFG_DWIDTH + 1)'(2 ** CONVERT_SHIFT - 1))
                >> CONVERT_SHIFT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         bl_q       <= '0;
         outst_q    <= '0;
         dlen_q     <= '0;
         awlen_q    <= '0;
         cfg_rdy_q  <= 1'b0;
         data_val_q <= 1'b0;
         awvalid_q  <= 1'b0;
         bready_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         outst_q <= outst_d;
         if (b_hs && bus.axi_bresp != 2'b00) error_q <= 1'b1;
         case (state_q)
            IDLE: begin
               cfg_rdy_q <= 1'b1;
               if (cfg_hs) begin
                  addr_q  <= bus.cfg_address & ~ADDR_WIDTH'(BYTES - 1);
                  rem_q   <= beats[CFG_DWIDTH-1:0];
                  dlen_q  <= bus.cfg_length;
                  error_q <= 1'b0;
                  if (bus.cfg_length == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     cfg_rdy_q  <= 1'b0;
                     data_val_q <= 1'b1;
                     state_q    <= DCFG;
                  end
               end
            end
            DCFG: begin
               if (d_hs) begin
                  data_val_q <= 1'b0;
                  bl_q       <= calc_bl(addr_q, rem_q);
                  awlen_q    <= AXI_LEN_WIDTH'(calc_bl(addr_q, rem_q) - 1'b1);
                  awvalid_q  <= (outst_q != MAX_OUT);
                  bready_q   <= 1'b1;
                  state_q    <= ADDR;
               end
            end
            ADDR: begin
               // Next burst is sized in the handshake cycle so AWs can go back to back.
               if (aw_hs) begin
                  addr_q  <= addr_d;
                  rem_q   <= rem_d;
                  bl_q    <= bl_d;
                  awlen_q <= AXI_LEN_WIDTH'(bl_d - 1'b1);
                  if (rem_d == '0) begin
                     awvalid_q <= 1'b0;
                     state_q   <= DRAIN;
                  end else begin
                     awvalid_q <= (outst_d != MAX_OUT);
                  end
               end else if (!awvalid_q) begin
                  awvalid_q <= (outst_d != MAX_OUT);
               end
            end
            DRAIN: begin
               if (outst_d == '0) begin
                  done_q   <= 1'b1;
                  bready_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cfg_rdy     = cfg_rdy_q;
   assign bus.data_length = dlen_q;
   assign bus.data_val    = data_val_q;
   assign bus.axi_awaddr  = addr_q;
   assign bus.axi_awlen   = awlen_q;
   assign bus.axi_awvalid = awvalid_q;
   assign bus.axi_bready  = bready_q;
   assign bus.done        = done_q;
   assign bus.error       = error_q;
   assign state_o         = state_q;
endmodule

// File: tb/tb_axis_write_ctrl.sv
// Directed bench for axis_write_ctrl: expected AW bursts and data lengths are queued
// when a request is driven and checked as the controller issues them.
module tb_axis_write_ctrl;
   logic       clk;
   logic       rst;
   logic [1:0] state_o;

   axis_write_ctrl_if bus_if ();

   axis_write_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if),
      .state_o (state_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [35:0] exp_aw_q[$];
   logic [31:0] exp_dl_q[$];
   int n_vec, n_err;
   int cyc, cfg_cyc, dv_first, dfire_cyc, aw_first, bfire_cyc, done_cyc;
   int aw_seen, b_seen, dv_seen, done_seen, pending_b;
   int b_limit, err_idx;
   bit cfg_fire;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      n_vec++;
      n_err++;
      $error("FAIL %s: observed timeout/unexpected expected event", tag);
   endtask

   // One clock: sample at negedge (handshakes land on the next posedge), then
   // drive the B responder just after that posedge.
   task automatic tick();
      @(negedge clk);
      if (bus_if.cfg_val && bus_if.cfg_rdy) begin
         cfg_fire = 1'b1;
         cfg_cyc  = cyc;
         dv_first = -1;
         aw_first = -1;
      end
      if (bus_if.data_val && dv_first < 0) dv_first = cyc;
      if (bus_if.data_val && bus_if.data_rdy) begin
         dfire_cyc = cyc;
         dv_seen++;
         if (exp_dl_q.size() == 0) fail_now("data_unexpected");
         else check("data_length", 64'(bus_if.data_length), 64'(exp_dl_q.pop_front()));
      end
      if (bus_if.axi_awvalid && aw_first < 0) aw_first = cyc;
      if (bus_if.axi_awvalid && bus_if.axi_awready) begin
         aw_seen++;
         pending_b++;
         if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
         else check("aw_addr_len", 64'({bus_if.axi_awaddr, bus_if.axi_awlen}),
                    64'(exp_aw_q.pop_front()));
      end
      if (bus_if.axi_bvalid && bus_if.axi_bready) begin
         b_seen++;
         pending_b--;
         bfire_cyc = cyc;
      end
      if (bus_if.done) begin
         done_seen++;
         done_cyc = cyc;
         check("done_pending_b", 64'(pending_b), 64'd0);
      end
      cyc++;
      @(posedge clk);
      #1;
      bus_if.axi_bvalid = (pending_b > 0) && (b_seen < b_limit);
      bus_if.axi_bresp  = (b_seen == err_idx) ? 2'b10 : 2'b00;
   endtask

   task automatic send_cfg(input logic [31:0] addr, input logic [31:0] len);
      bus_if.cfg_address = addr;
      bus_if.cfg_length  = len;
      bus_if.cfg_val     = 1'b1;
      cfg_fire = 1'b0;
      for (int i = 0; i < 50 && !cfg_fire; i++) tick();
      if (!cfg_fire) fail_now("cfg_timeout");
      bus_if.cfg_val = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 3000 && done_seen == d0; i++) tick();
      if (done_seen == d0) fail_now("done_timeout");
   endtask

   task automatic do_xfer(input logic [31:0] addr, input logic [31:0] len, input int n_aw);
      int d0, a0, v0;
      d0 = done_seen;
      a0 = aw_seen;
      v0 = dv_seen;
      if (len != 0) exp_dl_q.push_back(len);
      send_cfg(addr, len);
      wait_done(d0);
      repeat (4) tick();
      check("done_count", 64'(done_seen - d0), 64'd1);
      check("aw_count", 64'(aw_seen - a0), 64'(n_aw));
      check("dv_count", 64'(dv_seen - v0), (len != 0) ? 64'd1 : 64'd0);
      check("aw_queue_left", 64'(exp_aw_q.size()), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int a0;
      n_vec = 0; n_err = 0; cyc = 0;
      aw_seen = 0; b_seen = 0; dv_seen = 0; done_seen = 0; pending_b = 0;
      cfg_cyc = 0; dv_first = -1; dfire_cyc = 0; aw_first = -1; bfire_cyc = 0; done_cyc = 0;
      b_limit = 1 << 30;
      err_idx = -1;
      cfg_fire = 1'b0;
      rst = 1'b0;
      bus_if.cfg_address = '0;
      bus_if.cfg_length  = '0;
      bus_if.cfg_val     = 1'b0;
      bus_if.data_rdy    = 1'b1;
      bus_if.axi_awready = 1'b1;
      bus_if.axi_bresp   = 2'b00;
      bus_if.axi_bvalid  = 1'b0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg_rdy", 64'(bus_if.cfg_rdy), 64'd0);
      check("rst_flags", 64'({bus_if.data_val, bus_if.axi_awvalid, bus_if.axi_bready,
                              bus_if.done, bus_if.error}), 64'd0);
      check("rst_awaddr_len", 64'({bus_if.axi_awaddr, bus_if.axi_awlen}), 64'd0);
      check("rst_data_length", 64'(bus_if.data_length), 64'd0);
      check("rst_state", 64'(state_o), 64'd0);
      rst = 1'b1;
      repeat (2) tick();
      check("idle_cfg_rdy", 64'(bus_if.cfg_rdy), 64'd1);

      // basic transfer: 8 words -> 4 beats
      exp_aw_q.push_back({32'h0000_1000, 4'd3});
      do_xfer(32'h0000_1000, 32'd8, 1);
      check("lat_cfg_to_dval", 64'(dv_first - cfg_cyc), 64'd1);
      check("lat_data_to_aw", 64'(aw_first - dfire_cyc), 64'd1);
      check("lat_b_to_done", 64'(done_cyc - bfire_cyc), 64'd1);
      check("basic_error", 64'(bus_if.error), 64'd0);

      // burst split: 33 beats; unaligned low bits are dropped
      exp_aw_q.push_back({32'h0000_0000, 4'd15});
      exp_aw_q.push_back({32'h0000_0080, 4'd15});
      exp_aw_q.push_back({32'h0000_0100, 4'd0});
      do_xfer(32'h0000_0005, 32'd66, 3);

      // 4 KB boundary
      exp_aw_q.push_back({32'h0000_0FC0, 4'd7});
      exp_aw_q.push_back({32'h0000_1000, 4'd7});
      do_xfer(32'h0000_0FC0, 32'd32, 2);

      // outstanding limit: 320 beats = 20 bursts of 16, B channel held off
      for (int i = 0; i < 20; i++) exp_aw_q.push_back({32'(i * 128), 4'd15});
      b_limit = b_seen;
      a0 = aw_seen;
      exp_dl_q.push_back(32'd640);
      send_cfg(32'h0, 32'd640);
      repeat (30) tick();
      check("outst_aw_8", 64'(aw_seen - a0), 64'd8);
      check("outst_awvalid_off", 64'(bus_if.axi_awvalid), 64'd0);
      b_limit = b_seen + 1;
      repeat (10) tick();
      check("outst_one_b_one_aw", 64'(aw_seen - a0), 64'd9);
      check("outst_awvalid_off2", 64'(bus_if.axi_awvalid), 64'd0);
      b_limit = b_seen + 2;
      repeat (10) tick();
      check("outst_simul_aw_b", 64'(aw_seen - a0), 64'd11);
      check("outst_awvalid_off3", 64'(bus_if.axi_awvalid), 64'd0);
      b_limit = 1 << 30;
      wait_done(done_seen);
      repeat (3) tick();
      check("outst_aw_total", 64'(aw_seen - a0), 64'd20);
      check("outst_queue_left", 64'(exp_aw_q.size()), 64'd0);

      // error response on the second B
      err_idx = b_seen + 1;
      exp_aw_q.push_back({32'h0000_2000, 4'd15});
      exp_aw_q.push_back({32'h0000_2080, 4'd15});
      exp_aw_q.push_back({32'h0000_2100, 4'd0});
      do_xfer(32'h0000_2000, 32'd66, 3);
      err_idx = -1;
      repeat (5) tick();
      check("error_sticky", 64'(bus_if.error), 64'd1);
      exp_aw_q.push_back({32'h0000_1000, 4'd3});
      do_xfer(32'h0000_1000, 32'd8, 1);
      check("error_cleared", 64'(bus_if.error), 64'd0);

      // reset mid-burst: AW stalled, then rst dropped asynchronously
      bus_if.axi_awready = 1'b0;
      exp_dl_q.push_back(32'd64);
      send_cfg(32'h0000_3000, 32'd64);
      repeat (4) tick();
      check("pre_rst_awvalid", 64'(bus_if.axi_awvalid), 64'd1);
      check("pre_rst_bready", 64'(bus_if.axi_bready), 64'd1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_flags", 64'({bus_if.axi_awvalid, bus_if.data_val, bus_if.axi_bready}),
            64'd0);
      pending_b = 0;
      exp_aw_q.delete();
      exp_dl_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      bus_if.axi_awready = 1'b1;
      repeat (2) tick();
      check("post_rst_cfg_rdy", 64'(bus_if.cfg_rdy), 64'd1);

      // zero length: done on the next cycle, no AW and no data_val
      do_xfer(32'h0000_0040, 32'd0, 0);
      check("zero_len_done_lat", 64'(done_cyc - cfg_cyc), 64'd1);
      check("zero_len_error", 64'(bus_if.error), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
